// File: rtl/adc_serial_reader_if.sv
// rtl/adc_serial_reader_if.sv - request, ADC serial and sample-output bundle for adc_serial_reader
//
// Signals:
//   clk_in   sample request (reader input)
//   adc_sdo  serial data from the ADC, MSB first (reader input)
//   adc_cnv  conversion-start line to the ADC (reader output)
//   adc_sck  serial clock to the ADC (reader output)
//   Vout     last completed sample, two's complement (reader output)
//   clk_out  new-sample strobe, rising edge = new Vout (reader output)
//   busy     high whenever the reader is not idle (reader output)
//   overrun  sticky flag, a request arrived while busy (reader output)
// Modports: master = the reader, slave = the ADC/request side.

interface adc_serial_reader_if;
    logic               clk_in;
    logic               adc_sdo;
    logic               adc_cnv;
    logic               adc_sck;
    logic signed [19:0] Vout;
    logic               clk_out;
    logic               busy;
    logic               overrun;

    modport master (
        input  clk_in,
        input  adc_sdo,
        output adc_cnv,
        output adc_sck,
        output Vout,
        output clk_out,
        output busy,
        output overrun
    );

    modport slave (
        output clk_in,
        output adc_sdo,
        input  adc_cnv,
        input  adc_sck,
        input  Vout,
        input  clk_out,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - 20-bit serial ADC reader: CNV pulse, SCK shift-in, strobed sample output
//
// Ports:
//   qzt_clk  system clock, all logic on its rising edge
//   reset    synchronous active-high reset
//   bus      adc_serial_reader_if.master (clk_in, adc_sdo in; adc_cnv, adc_sck,
//            Vout, clk_out, busy, overrun out)
// Parameters:
//   CLK_DIV      SCK half-period in qzt_clk cycles (1..255)
//   CONV_CYCLES  CNV high time in qzt_clk cycles (1..4095)
//   OUT_HIGH     clk_out high time in qzt_clk cycles (1..255)

module adc_serial_reader #(
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 100,
    parameter int OUT_HIGH    = 4
) (
    input  logic                 qzt_clk,
    input  logic                 reset,
    adc_serial_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic         clk_in_old;
    logic         req_edge;

    logic [11:0]  conv_cnt, conv_cnt_nxt;
    logic [7:0]   div_cnt, div_cnt_nxt;
    logic         sck_phase, sck_phase_nxt;   // 0 = low half of the bit, 1 = high half
    logic [4:0]   bit_cnt, bit_cnt_nxt;
    logic [7:0]   out_cnt, out_cnt_nxt;
    logic [19:0]  shift_reg, shift_reg_nxt;

    logic [19:0]  vout_q, vout_nxt;
    logic         cnv_q, cnv_nxt;
    logic         sck_q, sck_nxt;
    logic         clk_out_q, clk_out_nxt;
    logic         busy_q, busy_nxt;
    logic         overrun_q, overrun_nxt;

    assign req_edge = bus.clk_in & ~clk_in_old;

    always_comb begin
        state_nxt     = state;
        conv_cnt_nxt  = conv_cnt;
        div_cnt_nxt   = div_cnt;
        sck_phase_nxt = sck_phase;
        bit_cnt_nxt   = bit_cnt;
        out_cnt_nxt   = out_cnt;
        shift_reg_nxt = shift_reg;
        vout_nxt      = vout_q;
        // Any request edge outside IDLE is dropped and remembered here.
        overrun_nxt   = overrun_q | (req_edge && (state != IDLE));

        case (state)
            IDLE: begin
                if (req_edge) begin
                    state_nxt     = CONVERT;
                    conv_cnt_nxt  = 12'd0;
                    shift_reg_nxt = 20'd0;
                end
            end
            CONVERT: begin
                if (conv_cnt == 12'(CONV_CYCLES - 1)) begin
                    state_nxt     = SHIFT;
                    div_cnt_nxt   = 8'd0;
                    sck_phase_nxt = 1'b0;
                    bit_cnt_nxt   = 5'd0;
                end else begin
                    conv_cnt_nxt = conv_cnt + 12'd1;
                end
            end
            SHIFT: begin
                if (div_cnt == 8'(CLK_DIV - 1)) begin
                    div_cnt_nxt = 8'd0;
                    if (!sck_phase) begin
                        sck_phase_nxt = 1'b1;
                    end else begin
                        sck_phase_nxt = 1'b0;
                        if (bit_cnt == 5'd19) begin
                            // All 20 bits are already in shift_reg (bit 19 was
                            // captured at the start of this high phase).
                            state_nxt   = DONE;
                            out_cnt_nxt = 8'd0;
                            vout_nxt    = shift_reg;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end
            DONE: begin
                if (out_cnt == 8'(OUT_HIGH - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    out_cnt_nxt = out_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they switch together with it.
        cnv_nxt     = (state_nxt == CONVERT);
        sck_nxt     = (state_nxt == SHIFT) && sck_phase_nxt;
        clk_out_nxt = (state_nxt == DONE);
        busy_nxt    = (state_nxt != IDLE);

        // Capture sdo on the same edge that drives SCK from low to high.
        if (sck_nxt && !sck_q) begin
            shift_reg_nxt = {shift_reg[18:0], bus.adc_sdo};
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_in_old <= 1'b0;
            conv_cnt   <= 12'd0;
            div_cnt    <= 8'd0;
            sck_phase  <= 1'b0;
            bit_cnt    <= 5'd0;
            out_cnt    <= 8'd0;
            shift_reg  <= 20'd0;
            vout_q     <= 20'd0;
            cnv_q      <= 1'b0;
            sck_q      <= 1'b0;
            clk_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_in_old <= bus.clk_in;
            conv_cnt   <= conv_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            sck_phase  <= sck_phase_nxt;
            bit_cnt    <= bit_cnt_nxt;
            out_cnt    <= out_cnt_nxt;
            shift_reg  <= shift_reg_nxt;
            vout_q     <= vout_nxt;
            cnv_q      <= cnv_nxt;
            sck_q      <= sck_nxt;
            clk_out_q  <= clk_out_nxt;
            busy_q     <= busy_nxt;
            overrun_q  <= overrun_nxt;
        end
    end

    assign bus.adc_cnv = cnv_q;
    assign bus.adc_sck = sck_q;
    assign bus.Vout    = vout_q;
    assign bus.clk_out = clk_out_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule
